// File: rtl/commit_trap_ctrl.sv
// commit_trap_ctrl: commit-side trap sequencer.
// Watches the ROB head slot and arbitrates pending machine interrupts,
// synchronous exceptions and mret, in that order of precedence. It emits a
// one-cycle trap or mret strobe together with a backend flush, waits for the
// backend to drain, then issues a one-cycle fetch redirect.
// Optional build macro: TRAP_VECTORED_EN enables vectored interrupt targets
// (tvec + 4*code). When it is undefined, every trap redirects to tvec.

package commit_trap_pkg;
  localparam int XDEF = 64;
  localparam logic [1:0] MODE_U = 2'b00;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_M = 2'b11;

  // mstatus view; only MIE (bit 3) is consumed here
  typedef struct packed {
    logic [59:0] rsvd_hi;
    logic        mie;
    logic [2:0]  rsvd_lo;
  } mstatus_t;

  typedef struct packed {
    logic [1:0]      mode;
    mstatus_t        status;
    logic [XDEF-1:0] epc;
    logic            interrupt_vectored;
    logic [XDEF-1:0] tvec;
  } csr_in_pack_t;

  typedef struct packed {
    logic            has_trap;
    logic [XDEF-1:0] epc;
    logic [XDEF-1:0] cause;
    logic [XDEF-1:0] tval;
  } trap_pack_t;
endpackage

module commit_trap_ctrl
  import commit_trap_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  csr_in_pack_t    i_sysinfo,
  input  logic [2:0]      i_irq,
  input  logic [2:0]      i_irq_en,
  input  logic            i_commit_vld,
  input  logic [XDEF-1:0] i_commit_pc,
  input  logic            i_commit_except,
  input  logic [XDEF-1:0] i_commit_cause,
  input  logic [XDEF-1:0] i_commit_tval,
  input  logic            i_commit_mret,
  output logic            o_commit_ready,
  output logic            o_retire,
  output trap_pack_t      o_trap_handle,
  output logic            o_mret,
  output logic            o_flush,
  input  logic            i_flush_done,
  output logic            o_redirect_vld,
  output logic [XDEF-1:0] o_redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SIGNAL   = 2'd1,
    S_DRAIN    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_nxt_state;
  logic            r_has_trap, r_mret, r_flush, r_redirect_vld;
  logic [XDEF-1:0] r_epc, r_cause, r_tval, r_target;

  logic [2:0]      w_pend;
  logic            w_irq_ok, w_take_irq, w_is_trap, w_event;
  logic [3:0]      w_irq_code;
  logic [XDEF-1:0] w_irq_target;
  logic [XDEF-1:0] w_cap_epc, w_cap_cause, w_cap_tval, w_cap_target;
  logic            w_nxt_has_trap, w_nxt_mret, w_nxt_flush, w_nxt_redirect;
  logic            w_unused;

`ifdef TRAP_VECTORED_EN
  assign w_irq_target = i_sysinfo.interrupt_vectored
                      ? (i_sysinfo.tvec + {{(XDEF-6){1'b0}}, w_irq_code, 2'b00})
                      : i_sysinfo.tvec;
  assign w_unused     = ^{i_sysinfo.status.rsvd_hi, i_sysinfo.status.rsvd_lo};
`else
  assign w_irq_target = i_sysinfo.tvec;
  assign w_unused     = ^{i_sysinfo.status.rsvd_hi, i_sysinfo.status.rsvd_lo,
                          i_sysinfo.interrupt_vectored};
`endif

  // Interrupt qualification, priority encoding (MEI > MSI > MTI) and event detect
  always_comb begin
    w_pend     = i_irq & i_irq_en;
    w_irq_ok   = (i_sysinfo.mode < MODE_M) | i_sysinfo.status.mie;
    w_take_irq = i_commit_vld & w_irq_ok & (|w_pend);
    if (w_pend[2]) begin
      w_irq_code = 4'd11;
    end else if (w_pend[0]) begin
      w_irq_code = 4'd3;
    end else begin
      w_irq_code = 4'd7;
    end
    w_is_trap = w_take_irq | (i_commit_vld & i_commit_except);
    w_event   = w_is_trap | (i_commit_vld & i_commit_mret);
  end

  // Record and redirect target to capture when an event is accepted
  always_comb begin
    if (w_take_irq) begin
      w_cap_epc    = i_commit_pc;
      w_cap_cause  = {1'b1, {(XDEF-5){1'b0}}, w_irq_code};
      w_cap_tval   = {XDEF{1'b0}};
      w_cap_target = w_irq_target;
    end else if (i_commit_except) begin
      w_cap_epc    = i_commit_pc;
      w_cap_cause  = i_commit_cause;
      w_cap_tval   = i_commit_tval;
      w_cap_target = i_sysinfo.tvec;
    end else begin
      // mret produces no trap record: keep the previous one
      w_cap_epc    = r_epc;
      w_cap_cause  = r_cause;
      w_cap_tval   = r_tval;
      w_cap_target = i_sysinfo.epc;
    end
  end

  // Next-state and next-strobe decode
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_has_trap = 1'b0;
    w_nxt_mret     = 1'b0;
    w_nxt_flush    = 1'b0;
    w_nxt_redirect = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_event) begin
          w_nxt_state    = S_SIGNAL;
          w_nxt_has_trap = w_is_trap;
          w_nxt_mret     = ~w_is_trap;
          w_nxt_flush    = 1'b1;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_SIGNAL: w_nxt_state = S_DRAIN;
      S_DRAIN: begin
        if (i_flush_done) begin
          w_nxt_state    = S_REDIRECT;
          w_nxt_redirect = 1'b1;
        end else begin
          w_nxt_state = S_DRAIN;
        end
      end
      S_REDIRECT: w_nxt_state = S_IDLE;
      default:    w_nxt_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Registered one-cycle strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_has_trap     <= 1'b0;
      r_mret         <= 1'b0;
      r_flush        <= 1'b0;
      r_redirect_vld <= 1'b0;
    end else begin
      r_has_trap     <= w_nxt_has_trap;
      r_mret         <= w_nxt_mret;
      r_flush        <= w_nxt_flush;
      r_redirect_vld <= w_nxt_redirect;
    end
  end

  // Capture record and redirect target on event acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_epc    <= {XDEF{1'b0}};
      r_cause  <= {XDEF{1'b0}};
      r_tval   <= {XDEF{1'b0}};
      r_target <= {XDEF{1'b0}};
    end else if ((r_state == S_IDLE) && w_event) begin
      r_epc    <= w_cap_epc;
      r_cause  <= w_cap_cause;
      r_tval   <= w_cap_tval;
      r_target <= w_cap_target;
    end
  end

  assign o_commit_ready = (r_state == S_IDLE);
  assign o_retire       = i_commit_vld & o_commit_ready & ~w_take_irq & ~i_commit_except;
  assign o_trap_handle  = {r_has_trap, r_epc, r_cause, r_tval};
  assign o_mret         = r_mret;
  assign o_flush        = r_flush;
  assign o_redirect_vld = r_redirect_vld;
  assign o_redirect_pc  = r_target;

endmodule

// File: tb/tb_commit_trap_ctrl.sv
// Self-checking bench for commit_trap_ctrl: directed scenarios plus
// randomized commit slots checked against a rule-level reference model.
module tb_commit_trap_ctrl;
  import commit_trap_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  csr_in_pack_t sysinfo;
  logic [2:0]   irq, irq_en;
  logic         c_vld, c_except, c_mret, flush_done;
  logic [63:0]  c_pc, c_cause, c_tval;
  logic         ready, retire, mret_o, flush_o, redir_vld;
  logic [63:0]  redir_pc;
  trap_pack_t   trap;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  commit_trap_ctrl dut (
    .clk(clk), .rst(rst), .i_sysinfo(sysinfo), .i_irq(irq), .i_irq_en(irq_en),
    .i_commit_vld(c_vld), .i_commit_pc(c_pc), .i_commit_except(c_except),
    .i_commit_cause(c_cause), .i_commit_tval(c_tval), .i_commit_mret(c_mret),
    .o_commit_ready(ready), .o_retire(retire), .o_trap_handle(trap),
    .o_mret(mret_o), .o_flush(flush_o), .i_flush_done(flush_done),
    .o_redirect_vld(redir_vld), .o_redirect_pc(redir_pc)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: derive the expected response from the current slot
  task automatic predict(output bit ev, output bit is_trap, output bit e_retire,
                         output logic [63:0] e_epc, output logic [63:0] e_cause,
                         output logic [63:0] e_tval, output logic [63:0] e_tgt);
    int  order_bit[3];
    int  order_code[3];
    int  code;
    bit  irq_ok;
    logic [2:0] pend;
    order_bit  = '{2, 0, 1};
    order_code = '{11, 3, 7};
    code   = -1;
    pend   = irq & irq_en;
    irq_ok = (int'(sysinfo.mode) < 3) || (sysinfo.status.mie == 1'b1);
    if (c_vld && irq_ok) begin
      for (int i = 2; i >= 0; i--) begin
        if (pend[order_bit[i]]) code = order_code[i];
      end
    end
    ev = 1'b0; is_trap = 1'b0;
    e_epc = 64'd0; e_cause = 64'd0; e_tval = 64'd0; e_tgt = 64'd0;
    if (code >= 0) begin
      ev = 1'b1; is_trap = 1'b1;
      e_epc   = c_pc;
      e_cause = 64'h8000_0000_0000_0000 + 64'(code);
      e_tval  = 64'd0;
      e_tgt   = sysinfo.tvec;
`ifdef TRAP_VECTORED_EN
      if (sysinfo.interrupt_vectored) e_tgt = sysinfo.tvec + 64'(code) * 64'd4;
`endif
    end else if (c_vld && c_except) begin
      ev = 1'b1; is_trap = 1'b1;
      e_epc = c_pc; e_cause = c_cause; e_tval = c_tval; e_tgt = sysinfo.tvec;
    end else if (c_vld && c_mret) begin
      ev = 1'b1;
      e_tgt = sysinfo.epc;
    end
    e_retire = c_vld && (code < 0) && !c_except;
  endtask

  // Present the driven slot in IDLE and follow the whole response sequence.
  // Called just after a rising edge; returns just after a rising edge in IDLE.
  task automatic run_slot(input int d, input bit early_done);
    bit ev, tr, er;
    logic [63:0] ep, ec, et, eg;
    predict(ev, tr, er, ep, ec, et, eg);
    #1;
    check_val("idle_ready", 64'(ready), 64'd1);
    check_val("retire", 64'(retire), 64'(er));
    @(posedge clk); #1;
    c_vld = 1'b0; c_except = 1'b0; c_mret = 1'b0;
    if (!ev) begin
      check_val("noev_trap", 64'(trap.has_trap), 64'd0);
      check_val("noev_mret", 64'(mret_o), 64'd0);
      check_val("noev_flush", 64'(flush_o), 64'd0);
      check_val("noev_ready", 64'(ready), 64'd1);
      return;
    end
    check_val("sig_has_trap", 64'(trap.has_trap), 64'(tr));
    check_val("sig_mret", 64'(mret_o), 64'(!tr));
    check_val("sig_flush", 64'(flush_o), 64'd1);
    check_val("sig_ready", 64'(ready), 64'd0);
    check_val("sig_redir", 64'(redir_vld), 64'd0);
    if (tr) begin
      check_val("rec_epc", trap.epc, ep);
      check_val("rec_cause", trap.cause, ec);
      check_val("rec_tval", trap.tval, et);
    end
    flush_done = early_done;
    @(posedge clk); #1;
    check_val("drain_flush", 64'(flush_o), 64'd0);
    check_val("drain_trap", 64'(trap.has_trap | mret_o), 64'd0);
    check_val("drain_redir", 64'(redir_vld), 64'd0);
    c_vld = 1'b1;
    flush_done = (d == 0);
    #1;
    check_val("drain_ready", 64'(ready), 64'd0);
    check_val("drain_retire", 64'(retire), 64'd0);
    c_vld = 1'b0;
    for (int k = 0; k < d; k++) begin
      @(posedge clk); #1;
      check_val("wait_redir", 64'(redir_vld), 64'd0);
      flush_done = (k == d - 1);
    end
    @(posedge clk); #1;
    flush_done = 1'b0;
    check_val("redir_vld", 64'(redir_vld), 64'd1);
    check_val("redir_pc", redir_pc, eg);
    check_val("redir_flush", 64'(flush_o), 64'd0);
    if (tr) check_val("redir_rec_epc", trap.epc, ep);
    @(posedge clk); #1;
    check_val("post_redir", 64'(redir_vld), 64'd0);
    check_val("post_ready", 64'(ready), 64'd1);
  endtask

  task automatic clear_slot();
    c_vld = 1'b0; c_except = 1'b0; c_mret = 1'b0;
    c_pc = 64'd0; c_cause = 64'd0; c_tval = 64'd0;
    irq = 3'b000; irq_en = 3'b000;
    sysinfo = '0;
    sysinfo.mode = MODE_M;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, 64'(ready), 64'd1);
    check_val({tag, "_trap"}, 64'(trap.has_trap), 64'd0);
    check_val({tag, "_epc"}, trap.epc, 64'd0);
    check_val({tag, "_cause"}, trap.cause, 64'd0);
    check_val({tag, "_tval"}, trap.tval, 64'd0);
    check_val({tag, "_mret"}, 64'(mret_o), 64'd0);
    check_val({tag, "_flush"}, 64'(flush_o), 64'd0);
    check_val({tag, "_rvld"}, 64'(redir_vld), 64'd0);
    check_val({tag, "_rpc"}, redir_pc, 64'd0);
    check_val({tag, "_retire"}, 64'(retire), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    flush_done = 1'b0;
    clear_slot();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Illegal instruction
    sysinfo.tvec = 64'h8000_0100;
    c_vld = 1'b1; c_except = 1'b1; c_pc = 64'h8000_0010;
    c_cause = 64'd2; c_tval = 64'hdead;
    run_slot(0, 1'b0);

    // Interrupt arbitration, all sources pending
    clear_slot();
    sysinfo.status.mie = 1'b1; sysinfo.interrupt_vectored = 1'b1;
    sysinfo.tvec = 64'h1000;
    irq = 3'b111; irq_en = 3'b111; c_vld = 1'b1; c_pc = 64'h2000;
    run_slot(1, 1'b1);

    // Interrupt masked in M mode, then taken in U mode
    clear_slot();
    irq = 3'b010; irq_en = 3'b010; c_vld = 1'b1; c_pc = 64'h3000;
    run_slot(0, 1'b0);
    sysinfo.mode = MODE_U; c_vld = 1'b1; sysinfo.tvec = 64'h4000;
    run_slot(2, 1'b0);

    // mret with a late drain
    clear_slot();
    sysinfo.epc = 64'h8000_2000; c_vld = 1'b1; c_mret = 1'b1; c_pc = 64'h5000;
    run_slot(5, 1'b0);

    // Exception and mret in the same slot
    clear_slot();
    sysinfo.tvec = 64'h6000; sysinfo.epc = 64'h7000;
    c_vld = 1'b1; c_except = 1'b1; c_mret = 1'b1; c_pc = 64'h6100; c_cause = 64'd5;
    run_slot(0, 1'b0);

    // Randomized slots
    for (int n = 0; n < 200; n++) begin
      clear_slot();
      case ($urandom_range(0, 2))
        0: sysinfo.mode = MODE_U;
        1: sysinfo.mode = MODE_S;
        default: sysinfo.mode = MODE_M;
      endcase
      sysinfo.status.mie         = 1'($urandom_range(0, 1));
      sysinfo.interrupt_vectored = 1'($urandom_range(0, 1));
      sysinfo.tvec = {$urandom(), $urandom()};
      sysinfo.epc  = {$urandom(), $urandom()};
      irq    = 3'($urandom_range(0, 7));
      irq_en = 3'($urandom_range(0, 7));
      c_vld    = ($urandom_range(0, 3) != 0);
      c_except = ($urandom_range(0, 3) == 0);
      c_mret   = ($urandom_range(0, 3) == 0);
      c_pc     = {$urandom(), $urandom()};
      c_cause  = {1'b0, 31'($urandom()), $urandom()};
      c_tval   = {$urandom(), $urandom()};
      run_slot(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    // Reset asserted in DRAIN aborts the sequence
    clear_slot();
    sysinfo.tvec = 64'h9000;
    c_vld = 1'b1; c_except = 1'b1; c_pc = 64'h9100; c_cause = 64'd1;
    @(posedge clk); #1;
    clear_slot();
    check_val("rst_seq_sig", 64'(flush_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    flush_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_val("rst_no_redir", 64'(redir_vld), 64'd0);
      check_val("rst_no_flush", 64'(flush_o), 64'd0);
      check_val("rst_ready", 64'(ready), 64'd1);
    end
    flush_done = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
